// File: rtl/int_issue_queue.sv
// Integer issue queue: a compacting shift queue of integer ops that wake up
// from the CDB. The lowest-index (oldest) ready entry is offered to issue_unit.
// Optional build macro: ISSUE_QUEUE_FLUSH_EN adds a flush input that clears the queue.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef ISSUE_QUEUE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              dispatch_en,
  input  logic [OP_W-1:0]   dispatch_op,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic              dispatch_rs1_valid,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic              dispatch_rs2_valid,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              issue_int,
  output logic              ready_int,
  output logic [OP_W-1:0]   issue_op,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic              queue_full,
  output logic [CNT_W-1:0]  queue_count
);

  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } opnd_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rd_tag;
    opnd_t            rs1;
    opnd_t            rs2;
  } entry_t;

  entry_t [DEPTH-1:0] q, q_nxt, up;
  logic   [DEPTH-1:0] rdy, shift;
  logic   [CNT_W-1:0] count, count_nxt, wr_idx;
  logic               do_issue, do_disp;
  entry_t             disp_e;

  // A waiting operand captures the broadcast when its tag matches.
  function automatic opnd_t wake(opnd_t o, logic cv, logic [TAG_W-1:0] ct,
                                 logic [DATA_W-1:0] cd);
    opnd_t r;
    r = o;
    if (!o.vld && cv && o.tag == ct) begin
      r.vld  = 1'b1;
      r.data = cd;
    end
    return r;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = q[g].valid & q[g].rs1.vld & q[g].rs2.vld;
  end

  // Oldest-ready pick; shift marks every slot at or above the pick.
  always_comb begin
    logic seen;
    seen           = 1'b0;
    shift          = '0;
    issue_op       = '0;
    issue_rd_tag   = '0;
    issue_rs1_data = '0;
    issue_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !seen) begin
        issue_op       = q[i].op;
        issue_rd_tag   = q[i].rd_tag;
        issue_rs1_data = q[i].rs1.data;
        issue_rs2_data = q[i].rs2.data;
      end
      seen     = seen | rdy[i];
      shift[i] = seen;
    end
    ready_int = seen;
  end

  assign queue_count = count;
  assign queue_full  = (count == CNT_W'(DEPTH));
  assign do_issue    = issue_int & ready_int;
  // A full queue drops the dispatch even if an issue frees a slot this cycle.
  assign do_disp     = dispatch_en & ~queue_full;
  assign wr_idx      = count - CNT_W'(do_issue);
  assign count_nxt   = count + CNT_W'(do_disp) - CNT_W'(do_issue);
  // Each slot's upper neighbour; the top slot pulls in an empty entry.
  assign up          = {entry_t'('0), q[DEPTH-1:1]};

  // New entry, with operands bypassed from a same-cycle broadcast.
  always_comb begin
    disp_e        = '0;
    disp_e.valid  = 1'b1;
    disp_e.op     = dispatch_op;
    disp_e.rd_tag = dispatch_rd_tag;
    disp_e.rs1    = wake('{dispatch_rs1_valid, dispatch_rs1_tag, dispatch_rs1_data},
                         cdb_valid, cdb_tag, cdb_data);
    disp_e.rs2    = wake('{dispatch_rs2_valid, dispatch_rs2_tag, dispatch_rs2_data},
                         cdb_valid, cdb_tag, cdb_data);
  end

  // Next queue image: compact over the issued slot, wake, then append dispatch.
  always_comb begin
    q_nxt = q;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && shift[i]) q_nxt[i] = up[i];
      if (q_nxt[i].valid) begin
        q_nxt[i].rs1 = wake(q_nxt[i].rs1, cdb_valid, cdb_tag, cdb_data);
        q_nxt[i].rs2 = wake(q_nxt[i].rs2, cdb_valid, cdb_tag, cdb_data);
      end
      if (do_disp && wr_idx == CNT_W'(i)) q_nxt[i] = disp_e;
    end
  end

  // Queue state register; reset (and flush when built in) drops every entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q     <= '0;
      count <= '0;
    end
`ifdef ISSUE_QUEUE_FLUSH_EN
    else if (flush) begin
      q     <= '0;
      count <= '0;
    end
`endif
    else begin
      q     <= q_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_int_issue_queue;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        flush;
  logic        dispatch_en;
  logic [3:0]  dispatch_op;
  logic [5:0]  dispatch_rd_tag;
  logic        dispatch_rs1_valid, dispatch_rs2_valid;
  logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_int;
  logic        ready_int;
  logic [3:0]  issue_op;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic        queue_full;
  logic [2:0]  queue_count;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd;
    bit          v1, v2;
    logic [5:0]  t1, t2;
    logic [31:0] d1, d2;
  } m_t;
  m_t mq[$];

  int_issue_queue dut (
    .i_clk(i_clk), .i_rst(i_rst),
`ifdef ISSUE_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .dispatch_en(dispatch_en), .dispatch_op(dispatch_op), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_data(dispatch_rs1_data),
    .dispatch_rs2_valid(dispatch_rs2_valid), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs2_data(dispatch_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_int(issue_int), .ready_int(ready_int), .issue_op(issue_op),
    .issue_rd_tag(issue_rd_tag), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .queue_full(queue_full), .queue_count(queue_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].v1 && mq[i].v2) return i;
    return -1;
  endfunction

  // Model step at a clock edge, using the inputs held across that edge.
  task automatic model_update();
    int  s;
    bit  was_full;
    m_t  e;
    s        = first_ready();
    was_full = (mq.size() == DEPTH);
    if (flush) begin
      mq.delete();
      return;
    end
    if (cdb_valid)
      foreach (mq[i]) begin
        if (!mq[i].v1 && mq[i].t1 == cdb_tag) begin mq[i].v1 = 1; mq[i].d1 = cdb_data; end
        if (!mq[i].v2 && mq[i].t2 == cdb_tag) begin mq[i].v2 = 1; mq[i].d2 = cdb_data; end
      end
    if (issue_int && s >= 0) mq.delete(s);
    if (dispatch_en && !was_full) begin
      e.op = dispatch_op; e.rd = dispatch_rd_tag;
      e.v1 = dispatch_rs1_valid; e.t1 = dispatch_rs1_tag; e.d1 = dispatch_rs1_data;
      e.v2 = dispatch_rs2_valid; e.t2 = dispatch_rs2_tag; e.d2 = dispatch_rs2_data;
      if (cdb_valid && !e.v1 && e.t1 == cdb_tag) begin e.v1 = 1; e.d1 = cdb_data; end
      if (cdb_valid && !e.v2 && e.t2 == cdb_tag) begin e.v2 = 1; e.d2 = cdb_data; end
      mq.push_back(e);
    end
  endtask

  task automatic check_model();
    int s;
    s = first_ready();
    chk("ready", ready_int, s >= 0);
    chk("count", queue_count, mq.size());
    chk("full", queue_full, mq.size() == DEPTH);
    chk("op",  issue_op,       (s >= 0) ? mq[s].op : 4'h0);
    chk("rd",  issue_rd_tag,   (s >= 0) ? mq[s].rd : 6'h0);
    chk("rs1", issue_rs1_data, (s >= 0) ? mq[s].d1 : 32'h0);
    chk("rs2", issue_rs2_data, (s >= 0) ? mq[s].d2 : 32'h0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    check_model();
  endtask

  task automatic idle();
    flush = 0; dispatch_en = 0; dispatch_op = 0; dispatch_rd_tag = 0;
    dispatch_rs1_valid = 0; dispatch_rs1_tag = 0; dispatch_rs1_data = 0;
    dispatch_rs2_valid = 0; dispatch_rs2_tag = 0; dispatch_rs2_data = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; issue_int = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                      input bit v1, input logic [5:0] t1, input logic [31:0] d1,
                      input bit v2, input logic [5:0] t2, input logic [31:0] d2);
    dispatch_en = 1; dispatch_op = op; dispatch_rd_tag = rd;
    dispatch_rs1_valid = v1; dispatch_rs1_tag = t1; dispatch_rs1_data = d1;
    dispatch_rs2_valid = v2; dispatch_rs2_tag = t2; dispatch_rs2_data = d2;
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    idle();
    #2 i_rst = 1;
    #1;
    chk("rst_ready", ready_int, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_full", queue_full, 0);
    chk("rst_rd", issue_rd_tag, 0);
    mq.delete();
    @(negedge i_clk);
    i_rst = 0;
  endtask

  initial begin
    idle();
    i_rst = 1;
    @(negedge i_clk);
    chk("init_ready", ready_int, 0);
    chk("init_count", queue_count, 0);
    chk("init_full", queue_full, 0);
    @(negedge i_clk);
    i_rst = 0;

    // 1: all-valid dispatch is ready next cycle, issue removes it
    disp(4'd3, 6'h0A, 1, 6'h00, 32'd1, 1, 6'h00, 32'd2);
    tick();
    chk("t1_ready", ready_int, 1);
    chk("t1_rs1", issue_rs1_data, 1);
    chk("t1_rs2", issue_rs2_data, 2);
    chk("t1_rd", issue_rd_tag, 6'h0A);
    idle(); issue_int = 1;
    tick();
    chk("t1_count", queue_count, 0);
    chk("t1_gone", ready_int, 0);

    // 2: waits on tag 0x0B until the broadcast
    idle(); disp(4'd1, 6'h01, 0, 6'h0B, 32'h0, 1, 6'h00, 32'h9);
    tick();
    idle();
    repeat (3) begin tick(); chk("t2_wait", ready_int, 0); end
    cdb_valid = 1; cdb_tag = 6'h0B; cdb_data = 32'h22;
    tick();
    chk("t2_ready", ready_int, 1);
    chk("t2_rs1", issue_rs1_data, 32'h22);
    async_reset();

    // 3: fill, drop the overflow dispatch, drain in order
    for (int k = 0; k < 5; k++) begin
      idle(); disp(4'(k), 6'(8'h10 + k), 1, 6'h0, 32'(k), 1, 6'h0, 32'(k + 100));
      tick();
    end
    chk("t3_count", queue_count, 4);
    chk("t3_full", queue_full, 1);
    idle(); issue_int = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", issue_rd_tag, 6'(8'h10 + k));
      tick();
    end
    chk("t3_empty", queue_count, 0);
    idle();

    // 4: younger ready entry issues first; older one wakes while shifting
    disp(4'd2, 6'h20, 0, 6'h0C, 32'h0, 1, 6'h0, 32'h5);
    tick();
    disp(4'd4, 6'h21, 1, 6'h0, 32'h6, 1, 6'h0, 32'h7);
    tick();
    chk("t4_first", issue_rd_tag, 6'h21);
    idle(); issue_int = 1; cdb_valid = 1; cdb_tag = 6'h0C; cdb_data = 32'h77;
    tick();
    chk("t4_ready", ready_int, 1);
    chk("t4_rd", issue_rd_tag, 6'h20);
    chk("t4_rs1", issue_rs1_data, 32'h77);
    idle(); issue_int = 1;
    tick();

    // 5: dispatch bypass from a same-cycle broadcast
    idle(); disp(4'd5, 6'h05, 1, 6'h0, 32'h1, 0, 6'h0D, 32'h0);
    cdb_valid = 1; cdb_tag = 6'h0D; cdb_data = 32'h55;
    tick();
    chk("t5_ready", ready_int, 1);
    chk("t5_rs2", issue_rs2_data, 32'h55);

    // 6: async reset with three entries
    idle(); disp(4'd6, 6'h06, 0, 6'h3F, 32'h0, 1, 6'h0, 32'h0);
    tick(); tick();
    chk("t6_count", queue_count, 3);
    async_reset();

`ifdef ISSUE_QUEUE_FLUSH_EN
    idle(); disp(4'd7, 6'h07, 1, 6'h0, 32'h1, 1, 6'h0, 32'h2);
    tick(); tick();
    flush = 1;
    tick();
    chk("fl_count", queue_count, 0);
    chk("fl_ready", ready_int, 0);
    idle();
`endif

    // random traffic with a small tag space so wakeups collide often
    for (int c = 0; c < 600; c++) begin
      idle();
      dispatch_en        = ($urandom_range(0, 99) < 60);
      dispatch_op        = 4'($urandom);
      dispatch_rd_tag    = 6'($urandom);
      dispatch_rs1_valid = $urandom_range(0, 1) == 1;
      dispatch_rs1_tag   = 6'($urandom_range(0, 7));
      dispatch_rs1_data  = $urandom;
      dispatch_rs2_valid = $urandom_range(0, 1) == 1;
      dispatch_rs2_tag   = 6'($urandom_range(0, 7));
      dispatch_rs2_data  = $urandom;
      cdb_valid          = ($urandom_range(0, 99) < 40);
      cdb_tag            = 6'($urandom_range(0, 7));
      cdb_data           = $urandom;
      issue_int          = ($urandom_range(0, 99) < 50);
`ifdef ISSUE_QUEUE_FLUSH_EN
      flush              = ($urandom_range(0, 99) < 3);
`endif
      tick();
      if (c == 300) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
